button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 117 +++++++++++
 tb/tb_button_conditioner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Three-channel pushbutton conditioner: synchronizes raw buttons, debounces
// each one with a saturating counter, and turns debounced presses into
// mutually exclusive one-cycle pulses (reset > stop > start).
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_start_raw,
   input  logic button_stop_raw,
   input  logic button_reset_raw,
   output logic start_pulse,
   output logic stop_pulse,
   output logic reset_pulse,
   output logic start_level,
   output logic stop_level,
   output logic reset_level
);

   // Counter value on which a persistent difference is finally accepted.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   // Channel index: 0 = start, 1 = stop, 2 = reset.
   logic [2:0] raw_in;
   logic [2:0] sync1_q;
   logic [2:0] sync2_q;
   logic [2:0] level_vec;
   logic [2:0] press_vec;
   logic [2:0] pulse_q;
   logic [2:0] pulse_d;

   assign raw_in = {button_reset_raw, button_stop_raw, button_start_raw};

   // Two-flop synchronizer for all raw buttons.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic [CNT_WIDTH-1:0] cnt_q;
         logic [CNT_WIDTH-1:0] cnt_d;
         logic                 level_q;
         logic                 level_d;
         logic                 press;

         // Debounce: count consecutive disagreeing cycles, accept on the last one.
         always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            press   = 1'b0;
            if (sync2_q[gi] == level_q) begin
               cnt_d = '0;
            end else if (cnt_q >= CNT_LAST) begin
               // Saturating compare so the counter can never wrap.
               level_d = sync2_q[gi];
               cnt_d   = '0;
               press   = sync2_q[gi];
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         // Debounce counter and accepted level registers.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_q   <= '0;
               level_q <= 1'b0;
            end else begin
               cnt_q   <= cnt_d;
               level_q <= level_d;
            end
         end

         assign level_vec[gi] = level_q;
         assign press_vec[gi] = press;
      end
   endgenerate

   // Fixed-priority arbitration of same-edge presses; losers are discarded.
   always_comb begin
      pulse_d = '0;
      if (press_vec[2]) begin
         pulse_d = 3'b100;
      end else if (press_vec[1]) begin
         pulse_d = 3'b010;
      end else if (press_vec[0]) begin
         pulse_d = 3'b001;
      end
   end

   // Registered one-cycle press pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_q <= '0;
      end else begin
         pulse_q <= pulse_d;
      end
   end

   assign start_pulse = pulse_q[0];
   assign stop_pulse  = pulse_q[1];
   assign reset_pulse = pulse_q[2];
   assign start_level = level_vec[0];
   assign stop_level  = level_vec[1];
   assign reset_level = level_vec[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with DEBOUNCE_CYCLES=4: table-driven press
// scenarios, hand-written reset/bounce sequences and a randomized run, all
// shadowed cycle by cycle by a history-window reference model.
module tb_button_conditioner;

   localparam int D_C  = 4;
   localparam int LAT  = D_C + 1;   // edges from first sample to pulse assertion
   localparam int MAXE = 16384;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] raw_v = 3'b000;
   logic       start_pulse, stop_pulse, reset_pulse;
   logic       start_level, stop_level, reset_level;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   button_conditioner #(.DEBOUNCE_CYCLES(D_C), .CNT_WIDTH(3)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .button_start_raw (raw_v[0]),
      .button_stop_raw  (raw_v[1]),
      .button_reset_raw (raw_v[2]),
      .start_pulse      (start_pulse),
      .stop_pulse       (stop_pulse),
      .reset_pulse      (reset_pulse),
      .start_level      (start_level),
      .stop_level       (stop_level),
      .reset_level      (reset_level)
   );

   // ---------------- reference model ----------------
   // Keeps every raw sample since reset release; a level flips when the
   // synchronized value (raw seen two edges earlier) has disagreed with it on
   // each of the last D_C edges and no flip happened inside that window.
   logic [2:0] hist [MAXE];
   int         edge_n = 0;
   int         base_e = 0;
   int         m_last_acc [3];
   logic [2:0] m_level = 3'b000;
   logic [2:0] m_pulse = 3'b000;

   function automatic logic synced(input int ch, input int n);
      if (n - 2 < base_e) return 1'b0;
      return hist[n-2][ch];
   endfunction

   task automatic model_reset();
      m_level = 3'b000;
      m_pulse = 3'b000;
   endtask

   task automatic model_release();
      base_e = edge_n;
      for (int ch = 0; ch < 3; ch++) m_last_acc[ch] = edge_n - D_C;
   endtask

   task automatic model_edge();
      logic [2:0] press;
      logic       all_diff;
      press = 3'b000;
      if (edge_n >= MAXE) begin
         $display("FAIL model_overflow: edge %0d exceeds history %0d", edge_n, MAXE);
         $fatal(1);
      end
      hist[edge_n] = raw_v;
      for (int ch = 0; ch < 3; ch++) begin
         if (m_last_acc[ch] <= edge_n - D_C) begin
            all_diff = 1'b1;
            for (int j = 0; j < D_C; j++)
               if (synced(ch, edge_n - j) == m_level[ch]) all_diff = 1'b0;
            if (all_diff) begin
               m_level[ch]    = ~m_level[ch];
               m_last_acc[ch] = edge_n;
               if (m_level[ch]) press[ch] = 1'b1;
            end
         end
      end
      if (press[2])      m_pulse = 3'b100;
      else if (press[1]) m_pulse = 3'b010;
      else if (press[0]) m_pulse = 3'b001;
      else               m_pulse = 3'b000;
      edge_n++;
   endtask

   // ---------------- checking ----------------
   task automatic check_now();
      logic [2:0] p, l;
      p = {reset_pulse, stop_pulse, start_pulse};
      l = {reset_level, stop_level, reset_level == reset_level ? start_level : 1'b0};
      l = {reset_level, stop_level, start_level};
      tests_run++;
      if (p !== m_pulse || l !== m_level) begin
         tests_failed++;
         $display("FAIL model_cmp @%0t: pulse=%b level=%b expected pulse=%b level=%b",
                  $time, p, l, m_pulse, m_level);
      end
      tests_run++;
      if ($countones(p) > 1 || $isunknown(p)) begin
         tests_failed++;
         $display("FAIL pulse_exclusive @%0t: pulse=%b expected at most one bit", $time, p);
      end
   endtask

   task automatic check_int(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // One clock edge: update the model with the inputs the DUT sampled, then compare.
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check_now();
   endtask

   // ---------------- table-driven vectors ----------------
   typedef struct {
      string      name;
      logic [2:0] raw;
      int         hold;
      logic [2:0] exp_pulse;
      logic [2:0] exp_level;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int pcnt [3];
      int ptick [3];
      int ltick [3];
      logic [2:0] p, l;
      for (int ch = 0; ch < 3; ch++) begin pcnt[ch] = 0; ptick[ch] = -1; ltick[ch] = -1; end
      for (int t = 0; t < v.hold + 14; t++) begin
         raw_v = (t < v.hold) ? v.raw : 3'b000;
         tick();
         p = {reset_pulse, stop_pulse, start_pulse};
         l = {reset_level, stop_level, start_level};
         for (int ch = 0; ch < 3; ch++) begin
            if (p[ch]) begin pcnt[ch]++; if (ptick[ch] < 0) ptick[ch] = t; end
            if (l[ch] && ltick[ch] < 0) ltick[ch] = t;
         end
      end
      for (int ch = 0; ch < 3; ch++) begin
         check_int($sformatf("%s_pulse_count_ch%0d", v.name, ch), pcnt[ch], v.exp_pulse[ch] ? 1 : 0);
         check_int($sformatf("%s_pulse_edge_ch%0d", v.name, ch), ptick[ch], v.exp_pulse[ch] ? LAT : -1);
         check_int($sformatf("%s_level_edge_ch%0d", v.name, ch), ltick[ch], v.exp_level[ch] ? LAT : -1);
      end
      $display("[TB] vec %s: pulses start/stop/reset=%0d/%0d/%0d", v.name, pcnt[0], pcnt[1], pcnt[2]);
   endtask

   initial begin
      vec_t vecs [7];
      int   cnt, first, hold_left [3];

      vecs[0] = '{"clean_start",   3'b001, 20,  3'b001, 3'b001};
      vecs[1] = '{"glitch3_stop",  3'b010, 3,   3'b000, 3'b000};
      vecs[2] = '{"min_hold_stop", 3'b010, 4,   3'b010, 3'b010};
      vecs[3] = '{"simultaneous",  3'b111, 10,  3'b100, 3'b111};
      vecs[4] = '{"start_stop",    3'b011, 10,  3'b010, 3'b011};
      vecs[5] = '{"long_reset",    3'b100, 100, 3'b100, 3'b100};
      vecs[6] = '{"glitch3_start", 3'b001, 3,   3'b000, 3'b000};

      // Power-on reset: outputs must be 0 throughout.
      #1 rst_n = 1'b0;
      model_reset();
      #1 check_now();
      repeat (3) tick();
      rst_n = 1'b1;
      model_release();
      repeat (4) tick();
      $display("[TB] reset released");

      foreach (vecs[i]) run_vec(vecs[i]);

      // Bounce: samples 1,0,1,0 then steady 1; last rising sample at t=4.
      cnt = 0; first = -1;
      for (int t = 0; t < 30; t++) begin
         raw_v = (t < 4) ? ((t % 2 == 0) ? 3'b010 : 3'b000) : ((t < 16) ? 3'b010 : 3'b000);
         tick();
         if (stop_pulse) begin cnt++; if (first < 0) first = t; end
      end
      check_int("bounce_pulse_count", cnt, 1);
      check_int("bounce_pulse_edge", first, 4 + LAT);
      $display("[TB] bounce: stop pulses=%0d at t=%0d", cnt, first);

      // Release: level falls LAT edges after the first 0 sample, no pulse.
      raw_v = 3'b001;
      repeat (20) tick();
      cnt = 0; first = -1;
      for (int t = 0; t < 15; t++) begin
         raw_v = 3'b000;
         tick();
         if (start_pulse) cnt++;
         if (!start_level && first < 0) first = t;
      end
      check_int("release_pulse_count", cnt, 0);
      check_int("release_fall_edge", first, LAT);
      $display("[TB] release: start_level fell at t=%0d", first);

      // Reset mid-debounce with the button held through reset.
      raw_v = 3'b001;
      repeat (3) tick();
      rst_n = 1'b0;
      model_reset();
      #1 check_now();
      repeat (3) tick();
      rst_n = 1'b1;
      model_release();
      cnt = 0; first = -1;
      for (int t = 0; t < 15; t++) begin
         tick();
         if (start_pulse) begin cnt++; if (first < 0) first = t; end
      end
      check_int("held_reset_pulse_count", cnt, 1);
      check_int("held_reset_pulse_edge", first, LAT);
      raw_v = 3'b000;
      repeat (12) tick();
      $display("[TB] reset mid-debounce: start pulses=%0d at t=%0d", cnt, first);

      // Reset while a pulse is high, button released: nothing afterwards.
      raw_v = 3'b010;
      for (int t = 0; t <= LAT; t++) tick();
      check_int("midpulse_pulse_seen", int'(stop_pulse), 1);
      rst_n = 1'b0;
      raw_v = 3'b000;
      model_reset();
      #1 check_now();
      check_int("midpulse_pulse_cleared", int'(stop_pulse), 0);
      check_int("midpulse_level_cleared", int'(stop_level), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      model_release();
      cnt = 0;
      for (int t = 0; t < 15; t++) begin
         tick();
         if (stop_pulse) cnt++;
      end
      check_int("midpulse_residual_pulses", cnt, 0);
      $display("[TB] reset mid-pulse: residual pulses=%0d", cnt);

      // Randomized bursts with occasional asynchronous resets.
      for (int ch = 0; ch < 3; ch++) hold_left[ch] = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int ch = 0; ch < 3; ch++) begin
            if (hold_left[ch] == 0) begin
               raw_v[ch]     = 1'($urandom_range(0, 1));
               hold_left[ch] = $urandom_range(1, 8);
            end
            hold_left[ch]--;
         end
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1 check_now();
            repeat ($urandom_range(1, 2)) tick();
            rst_n = 1'b1;
            model_release();
         end
         tick();
         if (i % 500 == 499) $display("[TB] random burst ending at cycle %0d", i + 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
